// File: rtl/ipg_rresp_gen_if.sv
// Request, payload and IPG-output handshakes of the read-response generator.
interface ipg_rresp_gen_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LEN_WIDTH  = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic [55:0]           hdr_in;
  logic [55:0]           src_addr;
  logic [55:0]           dst_addr;
  logic [LEN_WIDTH-1:0]  req_len;
  logic [55:0]           data_in;
  logic                  data_valid;
  logic                  data_ready;
  logic [DATA_WIDTH-1:0] tx_ipg_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport slave (
    input  req_valid, hdr_in, src_addr, dst_addr, req_len, data_in, data_valid, tx_ready,
    output req_ready, data_ready, tx_ipg_data, tx_valid
  );

  modport master (
    output req_valid, hdr_in, src_addr, dst_addr, req_len, data_in, data_valid, tx_ready,
    input  req_ready, data_ready, tx_ipg_data, tx_valid
  );
endinterface

// File: rtl/ipg_rresp_gen.sv
// Read-response IPG generator: emits RESPFIRST header, source and destination
// address blocks, then req_len payload blocks ending in RESPLAST.
module ipg_rresp_gen #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic           clk,
  input  logic           reset,
  ipg_rresp_gen_if.slave bus,
  output logic           busy,
  output logic [15:0]    frame_cnt,
  output logic [15:0]    drop_cnt
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_SRC  = 3'd2;
  localparam logic [2:0] ST_DST  = 3'd3;
  localparam logic [2:0] ST_DATA = 3'd4;

  localparam logic [7:0] TYPE_FIRST = 8'h0b;
  localparam logic [7:0] TYPE_MID   = 8'h1b;
  localparam logic [7:0] TYPE_LAST  = 8'h2b;

  logic [2:0]            state_q, state_d;
  logic [55:0]           src_q, src_d;
  logic [55:0]           dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [15:0]           frame_q, frame_d;
  logic [15:0]           drop_q, drop_d;
  logic                  tx_done;
  logic                  data_take;

  assign tx_done        = tx_valid_q & bus.tx_ready;
  assign bus.req_ready  = (state_q == ST_IDLE);
  // Stop pulling payload once the final chunk has been loaded.
  assign bus.data_ready = (state_q == ST_DATA) && (rem_q != '0) &&
                          (!tx_valid_q || bus.tx_ready);
  assign data_take      = bus.data_valid & bus.data_ready;

  assign bus.tx_ipg_data = tx_data_q;
  assign bus.tx_valid    = tx_valid_q;
  assign busy            = (state_q != ST_IDLE);
  assign frame_cnt       = frame_q;
  assign drop_cnt        = drop_q;

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    rem_d      = rem_q;
    last_d     = last_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    frame_d    = frame_q;
    drop_d     = drop_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          src_d = bus.src_addr;
          dst_d = bus.dst_addr;
          rem_d = bus.req_len;
          if (bus.req_len == '0) begin
            drop_d = drop_q + 16'd1;
          end else begin
            // The header is latched straight into the output register.
            tx_data_d  = {bus.hdr_in, TYPE_FIRST};
            tx_valid_d = 1'b1;
            state_d    = ST_HDR;
          end
        end
      end
      ST_HDR: begin
        if (tx_done) begin
          tx_data_d = {src_q, TYPE_MID};
          state_d   = ST_SRC;
        end
      end
      ST_SRC: begin
        if (tx_done) begin
          tx_data_d = {dst_q, TYPE_MID};
          state_d   = ST_DST;
        end
      end
      ST_DST: begin
        if (tx_done) begin
          tx_valid_d = 1'b0;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tx_done) begin
          tx_valid_d = 1'b0;
          if (last_q) begin
            last_d  = 1'b0;
            frame_d = frame_q + 16'd1;
            state_d = ST_IDLE;
          end
        end
        if (data_take) begin
          tx_data_d  = {bus.data_in, (rem_q == LEN_WIDTH'(1)) ? TYPE_LAST : TYPE_MID};
          tx_valid_d = 1'b1;
          last_d     = (rem_q == LEN_WIDTH'(1));
          rem_d      = rem_q - LEN_WIDTH'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        tx_valid_d = 1'b0;
        last_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      rem_q      <= '0;
      last_q     <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      frame_q    <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      rem_q      <= rem_d;
      last_q     <= last_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      frame_q    <= frame_d;
      drop_q     <= drop_d;
    end
  end

endmodule
